// File: rtl/wb_queue_if.sv
// Write-back queue bus: producer handshake, regfile write port, forwarding lookups and status.
interface wb_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_reg;
    logic [WIDTH-1:0] in_data;
    logic             wr_stall;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [WIDTH-1:0] data_writeReg;
    logic [4:0]       fwd_regA;
    logic [4:0]       fwd_regB;
    logic             fwd_hitA;
    logic             fwd_hitB;
    logic [WIDTH-1:0] fwd_dataA;
    logic [WIDTH-1:0] fwd_dataB;
    logic [CW-1:0]    count;
    logic             empty;

    modport master (
        output in_valid, in_reg, in_data, wr_stall, fwd_regA, fwd_regB,
        input  in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, count, empty
    );

    modport slave (
        input  in_valid, in_reg, in_data, wr_stall, fwd_regA, fwd_regB,
        output in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, count, empty
    );
endinterface

// File: rtl/wb_queue.sv
// In-order register write-back queue feeding the regfile write port.
// Define WB_QUEUE_FWD_EN to compile in the newest-pending-value forwarding lookup.
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       clr,
    wb_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]       reg_mem  [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             is_empty;
    logic             push;
    logic             pop;

    assign full     = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);
    assign pop      = !is_empty && !bus.wr_stall;
    // r0 writes complete the handshake but never occupy an entry
    assign push     = bus.in_valid && !full && (bus.in_reg != 5'd0);

    // Pointer and occupancy state
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are only observed while counted as occupied
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr]  <= bus.in_reg;
            data_mem[wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready         = !full;
    assign bus.ctrl_writeEnable = pop;
    assign bus.ctrl_writeReg    = is_empty ? 5'd0 : reg_mem[rd_ptr];
    assign bus.data_writeReg    = is_empty ? '0 : data_mem[rd_ptr];
    assign bus.count            = cnt;
    assign bus.empty            = is_empty;

`ifdef WB_QUEUE_FWD_EN
    logic             hit_a;
    logic             hit_b;
    logic [WIDTH-1:0] fdata_a;
    logic [WIDTH-1:0] fdata_b;
    logic [PW-1:0]    idx;

    // Scan oldest to newest so the entry nearest the write pointer wins
    always_comb begin
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        fdata_a = '0;
        fdata_b = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < cnt) begin
                if ((bus.fwd_regA != 5'd0) && (reg_mem[idx] == bus.fwd_regA)) begin
                    hit_a   = 1'b1;
                    fdata_a = data_mem[idx];
                end
                if ((bus.fwd_regB != 5'd0) && (reg_mem[idx] == bus.fwd_regB)) begin
                    hit_b   = 1'b1;
                    fdata_b = data_mem[idx];
                end
            end
        end
    end

    assign bus.fwd_hitA  = hit_a;
    assign bus.fwd_hitB  = hit_b;
    assign bus.fwd_dataA = fdata_a;
    assign bus.fwd_dataB = fdata_b;
`else
    logic fwd_unused;
    assign fwd_unused    = ^{bus.fwd_regA, bus.fwd_regB};
    assign bus.fwd_hitA  = 1'b0;
    assign bus.fwd_hitB  = 1'b0;
    assign bus.fwd_dataA = '0;
    assign bus.fwd_dataB = '0;
`endif
endmodule
